// File: rtl/bram_port_ctrl_pkg.sv
// Shared constants for the BRAM port controller and its response FIFO.
package bram_port_ctrl_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 9;
    localparam int unsigned RSP_FIFO_DEPTH     = 2;
    localparam int unsigned RSP_CNT_WIDTH      = $clog2(RSP_FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_port_ctrl_rsp_fifo.sv
// Two-entry response FIFO with valid/ready on both sides; pointers are one bit
// wide, so they wrap modulo the depth of two.
module bram_port_ctrl_rsp_fifo
    import bram_port_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic [RSP_CNT_WIDTH-1:0] count
);

    logic [DATA_WIDTH-1:0]    mem_q [RSP_FIFO_DEPTH];
    logic                     wr_ptr_q;
    logic                     rd_ptr_q;
    logic [RSP_CNT_WIDTH-1:0] count_q;
    logic                     push;
    logic                     pop;

    always_comb begin
        in_ready  = (count_q != RSP_CNT_WIDTH'(RSP_FIFO_DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_data  = mem_q[rd_ptr_q];
        count     = count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RSP_FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + RSP_CNT_WIDTH'(push) - RSP_CNT_WIDTH'(pop);
        end
    end

endmodule

// File: rtl/bram_port_ctrl.sv
// Valid/ready front end for a read-first single-port BRAM with 1-cycle read latency.
// Optional BRAM_PORT_CTRL_WRITE_FIRST_EN: write responses return the written data.
module bram_port_ctrl
    import bram_port_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clka,
    input  logic                  rsta_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    localparam int unsigned PEND_W = RSP_CNT_WIDTH + 1;

    logic                     inflight_q;
    logic                     accept;
    logic                     rsp_pop;
    logic                     cap_ready;
    logic [DATA_WIDTH-1:0]    cap_data;
    logic [RSP_CNT_WIDTH-1:0] occ;
    logic [PEND_W-1:0]        pending;

    // Outstanding work after this edge's pop must leave room for one more capture.
    always_comb begin
        rsp_pop   = rsp_valid & rsp_ready;
        pending   = PEND_W'(inflight_q) + PEND_W'(occ) - PEND_W'(rsp_pop);
        req_ready = rsta_n & (pending < PEND_W'(RSP_FIFO_DEPTH));
        accept    = req_valid & req_ready;
        bram_we   = accept & req_we;
        bram_addr = req_addr;
        bram_din  = req_wdata;
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= accept;
        end
    end

`ifdef BRAM_PORT_CTRL_WRITE_FIRST_EN
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            wr_q    <= bram_we;
            wdata_q <= req_wdata;
        end
    end

    // The BRAM itself is read-first, so write data is bypassed from the request.
    always_comb begin
        cap_data = wr_q ? wdata_q : bram_dout;
    end
`else
    always_comb begin
        cap_data = bram_dout;
    end
`endif

    bram_port_ctrl_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (clka),
        .rst_n     (rsta_n),
        .in_valid  (inflight_q & cap_ready),
        .in_ready  (cap_ready),
        .in_data   (cap_data),
        .out_valid (rsp_valid),
        .out_ready (rsp_ready),
        .out_data  (rsp_rdata),
        .count     (occ)
    );

endmodule
